// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code writer.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WRITE
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK_CODE      = 8'hF0;
  localparam int         PS2_DATA_BITS       = 8;
  localparam int         PS2_TIMEOUT_DEFAULT = 100000;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic ps2_parity_ok(input logic [7:0] i_byte, input logic i_par);
    return ^{i_byte, i_par};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock conditioning: 2-FF synchroniser, FILTER_LEN-sample debounce and
// a one-cycle pulse on each accepted high-to-low transition.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // Idle PS/2 lines are high, so the chain resets high to avoid a phantom edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta  <= 1'b1;
      r_sync  <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_fall  <= 1'b0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      r_fall <= 1'b0;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_level <= r_sync;
        r_cnt   <= '0;
        r_fall  <= r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_fall = r_fall;

endmodule

// File: rtl/ps2_scan_writer.sv
// PS/2 frame deserialiser producing the address/data/wren stream for the scan RAM.
// Optional macro BREAK_FILTER_EN: drop 0xF0 break codes and the byte that follows.
module ps2_scan_writer
  import ps2_pkg::*;
#(
  parameter int ADDR_W         = 5,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ps2_clk,
  input  logic              ps2_dat,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        data,
  output logic              wren,
  output logic              frame_err,
  output logic              wrapped
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(PS2_DATA_BITS);

  ps2_state_e        r_state;
  ps2_state_e        w_state_nxt;
  logic              r_dat_meta;
  logic              r_dat_sync;
  logic              w_fall;
  logic [BW-1:0]     r_bit_cnt;
  logic [BW-1:0]     w_bit_cnt_nxt;
  logic [TW-1:0]     r_timeout;
  logic [TW-1:0]     w_timeout_nxt;
  logic [7:0]        r_shift;
  logic              r_parity;
  logic [7:0]        r_data;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wrapped;
  logic              r_frame_err;
  logic              w_frame_err_nxt;
  logic              w_shift_en;
  logic              w_par_en;
  logic              w_data_ld;
  logic              w_addr_inc;
`ifdef BREAK_FILTER_EN
  logic              r_skip;
  logic              w_skip_nxt;
`endif

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_raw   (ps2_clk),
    .o_fall  (w_fall)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_dat_meta <= ps2_dat;
      r_dat_sync <= r_dat_meta;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_timeout_nxt   = r_timeout;
    w_frame_err_nxt = 1'b0;
    w_shift_en      = 1'b0;
    w_par_en        = 1'b0;
    w_data_ld       = 1'b0;
    w_addr_inc      = 1'b0;
`ifdef BREAK_FILTER_EN
    w_skip_nxt      = r_skip;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_fall && !r_dat_sync) begin
          w_state_nxt   = ST_DATA;
          w_bit_cnt_nxt = '0;
          w_timeout_nxt = '0;
        end
      end
      ST_DATA, ST_PARITY, ST_STOP: begin
        if (w_fall) begin
          w_timeout_nxt = '0;
          if (r_state == ST_DATA) begin
            w_shift_en = 1'b1;
            if (r_bit_cnt == BW'(PS2_DATA_BITS - 1)) begin
              w_state_nxt = ST_PARITY;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            end
          end else if (r_state == ST_PARITY) begin
            w_par_en    = 1'b1;
            w_state_nxt = ST_STOP;
          end else if (r_dat_sync && ps2_parity_ok(r_shift, r_parity)) begin
`ifdef BREAK_FILTER_EN
            if (r_skip) begin
              w_skip_nxt  = 1'b0;
              w_state_nxt = ST_IDLE;
            end else if (r_shift == PS2_BREAK_CODE) begin
              w_skip_nxt  = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_data_ld   = 1'b1;
              w_state_nxt = ST_WRITE;
            end
`else
            w_data_ld   = 1'b1;
            w_state_nxt = ST_WRITE;
`endif
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = ST_IDLE;
          end
        end else if (r_timeout == TW'(TIMEOUT_CYCLES - 1)) begin
          // Stalled frame: abandon the partial byte.
          w_frame_err_nxt = 1'b1;
          w_timeout_nxt   = '0;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_timeout_nxt = r_timeout + 1'b1;
        end
      end
      ST_WRITE: begin
        w_addr_inc  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_timeout   <= '0;
      r_frame_err <= 1'b0;
      r_data      <= 8'h00;
      r_addr      <= '0;
      r_wrapped   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_timeout   <= w_timeout_nxt;
      r_frame_err <= w_frame_err_nxt;
      if (w_data_ld) r_data <= r_shift;
      if (w_addr_inc) begin
        r_addr <= r_addr + 1'b1;
        if (&r_addr) r_wrapped <= 1'b1;
      end
    end
  end

`ifdef BREAK_FILTER_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_skip <= 1'b0;
    else        r_skip <= w_skip_nxt;
  end
`endif

  // LSB arrives first, so right-shifting into the MSB leaves the byte aligned.
  always_ff @(posedge clock) begin
    if (w_shift_en) r_shift  <= {r_dat_sync, r_shift[7:1]};
    if (w_par_en)   r_parity <= r_dat_sync;
  end

  assign address   = r_addr;
  assign data      = r_data;
  assign wren      = (r_state == ST_WRITE);
  assign frame_err = r_frame_err;
  assign wrapped   = r_wrapped;

endmodule
